// File: rtl/lsu.sv
// Load/store responder: runs one EXU request at a time on a req/gnt/rvalid bus.
// A bounded timeout aborts stuck accesses; a late response after an abort is discarded.
module lsu #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hs_ex4ls_val,
  output logic        hs_ls4ex_rdy,
  input  logic [31:0] i_ls_adr,
  input  logic [31:0] i_ls_wdat,
  input  logic [3:0]  i_ls_wen,
  input  logic        i_ls_ren,
  output logic [31:0] o_ls_rdat,
  output logic        o_ls_err,
  output logic        o_busy,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t          r_state, w_state_nxt;
  logic [TO_W-1:0] r_cnt, w_cnt_nxt;
  logic            r_drop, w_drop_nxt;
  logic            r_req, w_req_nxt;
  logic            r_we, w_we_nxt;
  logic [3:0]      r_be, w_be_nxt;
  logic [31:0]     r_addr, w_addr_nxt;
  logic [31:0]     r_wdata, w_wdata_nxt;
  logic [31:0]     r_rdat, w_rdat_nxt;
  logic            r_err, w_err_nxt;
  logic            r_rdy, r_busy;
  logic            w_timeout;
  logic            w_unused_adr;

  assign w_unused_adr = ^i_ls_adr[1:0];
  assign w_timeout    = (r_cnt == TO_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, bus request and response capture
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_req_nxt   = r_req;
    w_we_nxt    = r_we;
    w_be_nxt    = r_be;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_rdat_nxt  = r_rdat;
    w_err_nxt   = r_err;
    // An owed response after a DATA abort is swallowed wherever it lands
    if (r_drop && mem_rvalid) begin
      w_drop_nxt = 1'b0;
    end else begin
      w_drop_nxt = r_drop;
    end
    case (r_state)
      S_IDLE: begin
        if (hs_ex4ls_val && !r_drop) begin
          w_addr_nxt  = {i_ls_adr[31:2], 2'b00};
          w_wdata_nxt = i_ls_wdat;
          w_we_nxt    = (i_ls_wen != 4'h0);
          w_be_nxt    = i_ls_ren ? 4'hF : i_ls_wen;
          w_cnt_nxt   = {TO_W{1'b0}};
          if (i_ls_ren && (i_ls_wen != 4'h0)) begin
            w_state_nxt = S_DONE;
            w_rdat_nxt  = 32'h0;
            w_err_nxt   = 1'b1;
          end else if (!i_ls_ren && (i_ls_wen == 4'h0)) begin
            w_state_nxt = S_DONE;
            w_rdat_nxt  = 32'h0;
            w_err_nxt   = 1'b0;
          end else begin
            w_state_nxt = S_ADDR;
            w_req_nxt   = 1'b1;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ADDR: begin
        w_cnt_nxt = r_cnt + TO_W'(1);
        if (w_timeout) begin
          w_state_nxt = S_DONE;
          w_req_nxt   = 1'b0;
          w_rdat_nxt  = 32'h0;
          w_err_nxt   = 1'b1;
          // A grant on the abort cycle still owes a response
          w_drop_nxt  = mem_gnt;
        end else if (mem_gnt) begin
          w_state_nxt = S_DATA;
          w_req_nxt   = 1'b0;
        end else begin
          w_state_nxt = S_ADDR;
        end
      end
      S_DATA: begin
        w_cnt_nxt = r_cnt + TO_W'(1);
        if (mem_rvalid && !r_drop) begin
          w_state_nxt = S_DONE;
          w_rdat_nxt  = r_we ? 32'h0 : mem_rdata;
          w_err_nxt   = mem_err;
        end else if (w_timeout) begin
          w_state_nxt = S_DONE;
          w_rdat_nxt  = 32'h0;
          w_err_nxt   = 1'b1;
          w_drop_nxt  = 1'b1;
        end else begin
          w_state_nxt = S_DATA;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_req_nxt   = 1'b0;
      end
    endcase
  end

  // Datapath and registered handshake/status outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt   <= {TO_W{1'b0}};
      r_drop  <= 1'b0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_be    <= 4'h0;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_rdat  <= 32'h0;
      r_err   <= 1'b0;
      r_rdy   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_drop  <= w_drop_nxt;
      r_req   <= w_req_nxt;
      r_we    <= w_we_nxt;
      r_be    <= w_be_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
      r_rdat  <= w_rdat_nxt;
      r_err   <= w_err_nxt;
      r_rdy   <= (w_state_nxt == S_DONE);
      r_busy  <= (w_state_nxt != S_IDLE) || w_drop_nxt;
    end
  end

  assign hs_ls4ex_rdy = r_rdy;
  assign o_busy       = r_busy;
  assign o_ls_rdat    = r_rdat;
  assign o_ls_err     = r_err;
  assign mem_req      = r_req;
  assign mem_we       = r_we;
  assign mem_be       = r_be;
  assign mem_addr     = r_addr;
  assign mem_wdata    = r_wdata;

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: stimulus pushes expected responses, a negedge monitor
// pops and compares them whenever the DUT pulses hs_ls4ex_rdy.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hs_ex4ls_val = 1'b0;
  logic        hs_ls4ex_rdy;
  logic [31:0] i_ls_adr = 32'h0;
  logic [31:0] i_ls_wdat = 32'h0;
  logic [3:0]  i_ls_wen = 4'h0;
  logic        i_ls_ren = 1'b0;
  logic [31:0] o_ls_rdat;
  logic        o_ls_err;
  logic        o_busy;
  logic        mem_req;
  logic        mem_gnt = 1'b0;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_err = 1'b0;

  lsu #(.TIMEOUT(8), .TO_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .hs_ex4ls_val(hs_ex4ls_val), .hs_ls4ex_rdy(hs_ls4ex_rdy),
    .i_ls_adr(i_ls_adr), .i_ls_wdat(i_ls_wdat), .i_ls_wen(i_ls_wen), .i_ls_ren(i_ls_ren),
    .o_ls_rdat(o_ls_rdat), .o_ls_err(o_ls_err), .o_busy(o_busy),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdat;
    logic        err;
    logic        chk_rdat;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor: every rdy pulse must match the oldest expectation
  always @(negedge clk) begin : mon
    exp_t e;
    if (hs_ls4ex_rdy === 1'b1) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_rdy: got rdy=1 expected no response (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
        if (e.chk_rdat) chk("rsp_rdat", o_ls_rdat, e.rdat);
        chk("rsp_err", {31'h0, o_ls_err}, {31'h0, e.err});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] rdat, input logic err, input logic chk_rdat, input int c);
    exp_t e;
    e.rdat = rdat; e.err = err; e.chk_rdat = chk_rdat; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic start_req(input logic ren, input logic [3:0] wen, input logic [31:0] adr,
                           input logic [31:0] wdat, output int c0);
    tick();
    hs_ex4ls_val = 1'b1; i_ls_ren = ren; i_ls_wen = wen; i_ls_adr = adr; i_ls_wdat = wdat;
    c0 = cyc;
  endtask

  // Hold val until the completion cycle, bounded
  task automatic finish_txn();
    bit seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (hs_ls4ex_rdy === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL rdy_wait: got no rdy expected rdy within 20 cycles (cycle %0d)", cyc);
    end
    hs_ex4ls_val = 1'b0;
  endtask

  task automatic fast_read(input logic [31:0] adr, input logic [31:0] rdata, input logic err);
    int c0;
    start_req(1'b1, 4'h0, adr, 32'h0, c0);
    push(rdata, err, 1'b1, c0 + 3);
    tick();
    mem_gnt = 1'b1;
    chk("rd_req", {31'h0, mem_req}, 32'h1);
    chk("rd_addr", mem_addr, {adr[31:2], 2'b00});
    chk("rd_be", {28'h0, mem_be}, 32'hF);
    chk("rd_we", {31'h0, mem_we}, 32'h0);
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = rdata; mem_err = err;
    chk("rd_req_drop", {31'h0, mem_req}, 32'h0);
    tick();
    mem_rvalid = 1'b0; mem_err = 1'b0; mem_rdata = 32'h0;
    finish_txn();
  endtask

  task automatic check_idle_outs(input string tag);
    chk({tag, "_rdy"}, {31'h0, hs_ls4ex_rdy}, 32'h0);
    chk({tag, "_busy"}, {31'h0, o_busy}, 32'h0);
    chk({tag, "_req"}, {31'h0, mem_req}, 32'h0);
    chk({tag, "_we"}, {31'h0, mem_we}, 32'h0);
    chk({tag, "_be"}, {28'h0, mem_be}, 32'h0);
    chk({tag, "_addr"}, mem_addr, 32'h0);
    chk({tag, "_wdata"}, mem_wdata, 32'h0);
    chk({tag, "_rdat"}, o_ls_rdat, 32'h0);
    chk({tag, "_err"}, {31'h0, o_ls_err}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000 time units");
    $fatal(1);
  end

  initial begin
    int c0;
    int c1;
    rst_n = 1'b0;
    tick(); tick();
    check_idle_outs("reset");
    rst_n = 1'b1;

    // Basic read, minimum latency
    fast_read(32'h0000_1003, 32'hDEAD_BEEF, 1'b0);

    // Write with grant stalled five cycles
    start_req(1'b0, 4'b1100, 32'h0000_2002, 32'hAB00_0000, c0);
    push(32'h0, 1'b0, 1'b1, c0 + 8);
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("wr_req_held", {31'h0, mem_req}, 32'h1);
      chk("wr_addr", mem_addr, 32'h0000_2000);
      chk("wr_be", {28'h0, mem_be}, 32'hC);
      chk("wr_we", {31'h0, mem_we}, 32'h1);
      chk("wr_wdata", mem_wdata, 32'hAB00_0000);
    end
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
    chk("wr_req_drop", {31'h0, mem_req}, 32'h0);
    tick();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    finish_txn();

    // Timeout in address phase, no grant ever
    start_req(1'b1, 4'h0, 32'h0000_3000, 32'h0, c0);
    push(32'h0, 1'b1, 1'b1, c0 + 9);
    repeat (8) tick();
    chk("to_req_before", {31'h0, mem_req}, 32'h1);
    tick();
    chk("to_req_after", {31'h0, mem_req}, 32'h0);
    finish_txn();
    tick();
    chk("to_busy_clear", {31'h0, o_busy}, 32'h0);
    fast_read(32'h0000_4008, 32'hCAFE_F00D, 1'b0);

    // Timeout in data phase, late response must be discarded
    start_req(1'b1, 4'h0, 32'h0000_5000, 32'h0, c0);
    push(32'h0, 1'b1, 1'b1, c0 + 9);
    tick();
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    repeat (7) tick();
    finish_txn();
    start_req(1'b1, 4'h0, 32'h0000_6004, 32'h0, c1);
    push(32'h0BAD_F00D, 1'b0, 1'b1, c1 + 6);
    tick();
    chk("drop_no_req", {31'h0, mem_req}, 32'h0);
    chk("drop_busy", {31'h0, o_busy}, 32'h1);
    tick();
    chk("drop_busy2", {31'h0, o_busy}, 32'h1);
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    chk("drop_busy_clear", {31'h0, o_busy}, 32'h0);
    chk("drop_req_low", {31'h0, mem_req}, 32'h0);
    tick();
    chk("drop_next_req", {31'h0, mem_req}, 32'h1);
    chk("drop_next_addr", mem_addr, 32'h0000_6004);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_F00D;
    tick();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    finish_txn();

    // Bus error, then response registers hold
    fast_read(32'h0000_7000, 32'h1111_2222, 1'b1);
    tick(); tick();
    chk("hold_rdat", o_ls_rdat, 32'h1111_2222);
    chk("hold_err", {31'h0, o_ls_err}, 32'h1);

    // Illegal read+write: error, no bus request
    start_req(1'b1, 4'b0011, 32'h0000_8000, 32'hFFFF_FFFF, c0);
    push(32'h0, 1'b1, 1'b0, c0 + 1);
    tick();
    chk("ill_no_req", {31'h0, mem_req}, 32'h0);
    finish_txn();
    tick();
    chk("ill_no_req2", {31'h0, mem_req}, 32'h0);

    // No-op request completes with zero data
    start_req(1'b0, 4'h0, 32'h0000_9000, 32'h0, c0);
    push(32'h0, 1'b0, 1'b1, c0 + 1);
    tick();
    finish_txn();

    // Reset during data phase: no response, everything cleared
    start_req(1'b1, 4'h0, 32'h0000_A000, 32'h0, c0);
    tick();
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0; rst_n = 1'b0; hs_ex4ls_val = 1'b0;
    tick();
    check_idle_outs("rst_data");
    rst_n = 1'b1;
    tick();
    chk("rst_post_busy", {31'h0, o_busy}, 32'h0);
    fast_read(32'h0000_B00C, 32'h0F0F_0F0F, 1'b0);

    tick(); tick();
    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
